// File: rtl/imem_pkg.sv
// Shared constants, requester identifiers and address checking for the instruction-ROM arbiter.
package imem_pkg;

  localparam int IMEM_XLEN  = 32;
  localparam int IMEM_DEPTH = 64;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // A request errors when it is not word aligned or its word index lies beyond the ROM.
  function automatic logic addr_check(input logic [IMEM_XLEN-1:0] addr,
                                      input int unsigned           depth);
    logic [IMEM_XLEN-1:0] word_idx;
    word_idx = {2'b00, addr[IMEM_XLEN-1:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/imem_resp_slot.sv
// Single registered response holder (EMPTY/FULL) with load, pop and flush controls.
module imem_resp_slot
  import imem_pkg::*;
#(
  parameter int XLEN = IMEM_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] data_i,
  input  logic            err_i,
  output logic            full_o,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);

  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;

  // Flush wins outright; a load in the same cycle as a pop keeps the slot FULL with new contents.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    if (flush_i) begin
      state_d = SLOT_EMPTY;
    end else if (load_i) begin
      state_d = SLOT_FULL;
      data_d  = err_i ? '0 : data_i;
      err_d   = err_i;
    end else if (pop_i) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign full_o = (state_q == SLOT_FULL);
  assign data_o = data_q;
  assign err_o  = err_q;

endmodule

// File: rtl/imem_arbiter.sv
// Shares the combinational instruction-ROM read port between fetch (F) and debug (D) requesters.
// Defining IMEM_ARB_STATS_EN adds grant and error counters as extra outputs.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int XLEN         = IMEM_XLEN,
  parameter int DEPTH        = IMEM_DEPTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_req_valid,
  output logic            f_req_ready,
  input  logic [XLEN-1:0] f_req_addr,
  output logic            f_resp_valid,
  input  logic            f_resp_ready,
  output logic [XLEN-1:0] f_resp_data,
  output logic            f_resp_err,
  input  logic            f_flush,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [XLEN-1:0] d_req_addr,
  output logic            d_resp_valid,
  input  logic            d_resp_ready,
  output logic [XLEN-1:0] d_resp_data,
  output logic            d_resp_err,
  output logic [XLEN-1:0] mem_a,
  input  logic [XLEN-1:0] mem_rd
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]     f_grant_cnt,
  output logic [31:0]     d_grant_cnt,
  output logic [31:0]     err_cnt
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic            f_full, d_full;
  logic            f_elig, d_elig;
  logic            grant_f, grant_d, grant_any;
  port_e           grant_port;
  logic [XLEN-1:0] grant_addr;
  logic            acc_err;
  logic [SW-1:0]   starve_q, starve_d;
  logic [XLEN-1:0] mem_a_q;

  // A full slot only frees up for a new request when its consumer pops it in the same cycle.
  assign f_elig = f_req_valid && (!f_full || f_resp_ready) && !f_flush;
  assign d_elig = d_req_valid && (!d_full || d_resp_ready);

  assign grant_d   = d_elig && (!f_elig || (starve_q == STARVE_MAX));
  assign grant_f   = f_elig && !grant_d;
  assign grant_any = grant_f || grant_d;

  assign grant_port = grant_d ? PORT_D : PORT_F;
  assign grant_addr = (grant_port == PORT_D) ? d_req_addr : f_req_addr;
  assign acc_err    = addr_check(grant_addr, unsigned'(DEPTH));

  assign f_req_ready = grant_f;
  assign d_req_ready = grant_d;

  // The ROM address stays parked on the last granted address while idle.
  assign mem_a = grant_any ? grant_addr : mem_a_q;

  always_comb begin
    starve_d = starve_q;
    if (grant_d) begin
      starve_d = '0;
    end else if (d_elig && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      mem_a_q  <= '0;
    end else begin
      starve_q <= starve_d;
      mem_a_q  <= mem_a;
    end
  end

  imem_resp_slot #(.XLEN(XLEN)) u_f_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (grant_f),
    .pop_i   (f_full && f_resp_ready),
    .flush_i (f_flush),
    .data_i  (mem_rd),
    .err_i   (acc_err),
    .full_o  (f_full),
    .data_o  (f_resp_data),
    .err_o   (f_resp_err)
  );

  imem_resp_slot #(.XLEN(XLEN)) u_d_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (grant_d),
    .pop_i   (d_full && d_resp_ready),
    .flush_i (1'b0),
    .data_i  (mem_rd),
    .err_i   (acc_err),
    .full_o  (d_full),
    .data_o  (d_resp_data),
    .err_o   (d_resp_err)
  );

  assign f_resp_valid = f_full;
  assign d_resp_valid = d_full;

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] f_grant_cnt_q, d_grant_cnt_q, err_cnt_q;

  // Free-running wrap-around counters of accepted requests and erroring responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_grant_cnt_q <= '0;
      d_grant_cnt_q <= '0;
      err_cnt_q     <= '0;
    end else begin
      if (grant_f)              f_grant_cnt_q <= f_grant_cnt_q + 32'd1;
      if (grant_d)              d_grant_cnt_q <= d_grant_cnt_q + 32'd1;
      if (grant_any && acc_err) err_cnt_q     <= err_cnt_q + 32'd1;
    end
  end

  assign f_grant_cnt = f_grant_cnt_q;
  assign d_grant_cnt = d_grant_cnt_q;
  assign err_cnt     = err_cnt_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: a cycle model predicts grants, and a per-port
// scoreboard of expected responses is compared while each response slot is held.
module tb_imem_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req_valid = 1'b0, f_resp_ready = 1'b0, f_flush = 1'b0;
  logic [31:0] f_req_addr = '0;
  logic        d_req_valid = 1'b0, d_resp_ready = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic        f_req_ready, f_resp_valid, f_resp_err;
  logic        d_req_ready, d_resp_valid, d_resp_err;
  logic [31:0] f_resp_data, d_resp_data, mem_a, mem_rd;

  int checks = 0;
  int failures = 0;
  int obsDGrants = 0;

  exp_t        fQ[$];
  exp_t        dQ[$];
  logic        mFFull = 1'b0, mDFull = 1'b0;
  int          mStarve = 0;
  logic [31:0] mMemA = '0;

  always #5 clk = ~clk;

  // Behavioural ROM: word 2 holds the known instruction, out-of-range words return junk.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    if (idx == 32'd2) return 32'h0050_0093;
    if (idx >= 32'd64) return 32'hBADC_0DE0;
    return {idx[15:0], 16'hC0DE} ^ 32'h1357_0000;
  endfunction

  function automatic exp_t expectResp(input logic [31:0] a);
    exp_t e;
    e.err  = ((a % 4) != 0) || (a >= 32'd256);
    e.data = e.err ? 32'h0 : romWord(a & ~32'h3);
    return e;
  endfunction

  assign mem_rd = romWord(mem_a);

  imem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .f_req_valid  (f_req_valid),
    .f_req_ready  (f_req_ready),
    .f_req_addr   (f_req_addr),
    .f_resp_valid (f_resp_valid),
    .f_resp_ready (f_resp_ready),
    .f_resp_data  (f_resp_data),
    .f_resp_err   (f_resp_err),
    .f_flush      (f_flush),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_addr   (d_req_addr),
    .d_resp_valid (d_resp_valid),
    .d_resp_ready (d_resp_ready),
    .d_resp_data  (d_resp_data),
    .d_resp_err   (d_resp_err),
    .mem_a        (mem_a),
    .mem_rd       (mem_rd)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check against the model, advance the model.
  task automatic applyStimulus(input logic fv, input logic [31:0] fa, input logic frr, input logic fl,
                               input logic dv, input logic [31:0] da, input logic drr);
    logic fElig, dElig, gF, gD;
    logic [31:0] expA;
    @(negedge clk);
    f_req_valid = fv; f_req_addr = fa; f_resp_ready = frr; f_flush = fl;
    d_req_valid = dv; d_req_addr = da; d_resp_ready = drr;
    #1;
    fElig = fv && (!mFFull || frr) && !fl;
    dElig = dv && (!mDFull || drr);
    gD = dElig && (!fElig || (mStarve == 4));
    gF = fElig && !gD;
    expA = gD ? da : (gF ? fa : mMemA);
    checkOutput("f_req_ready", {31'b0, f_req_ready}, {31'b0, gF});
    checkOutput("d_req_ready", {31'b0, d_req_ready}, {31'b0, gD});
    checkOutput("f_resp_valid", {31'b0, f_resp_valid}, {31'b0, mFFull});
    checkOutput("d_resp_valid", {31'b0, d_resp_valid}, {31'b0, mDFull});
    checkOutput("mem_a", mem_a, expA);
    if (mFFull) begin
      checkOutput("f_resp_data", f_resp_data, fQ[0].data);
      checkOutput("f_resp_err", {31'b0, f_resp_err}, {31'b0, fQ[0].err});
    end
    if (mDFull) begin
      checkOutput("d_resp_data", d_resp_data, dQ[0].data);
      checkOutput("d_resp_err", {31'b0, d_resp_err}, {31'b0, dQ[0].err});
    end
    if (d_req_ready) obsDGrants++;
    if (mFFull && (fl || frr)) begin
      void'(fQ.pop_front());
      mFFull = 1'b0;
    end
    if (mDFull && drr) begin
      void'(dQ.pop_front());
      mDFull = 1'b0;
    end
    if (gF) begin
      fQ.push_back(expectResp(fa));
      mFFull = 1'b1;
    end
    if (gD) begin
      dQ.push_back(expectResp(da));
      mDFull = 1'b1;
    end
    if (gD) mStarve = 0;
    else if (dElig && (mStarve < 4)) mStarve++;
    mMemA = expA;
    @(posedge clk);
  endtask

  // Reset asserted between clock edges must clear the response slots immediately.
  task automatic doReset();
    @(negedge clk);
    f_req_valid = 1'b0; f_req_addr = '0; f_resp_ready = 1'b0; f_flush = 1'b0;
    d_req_valid = 1'b0; d_req_addr = '0; d_resp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_f_resp_valid", {31'b0, f_resp_valid}, 32'd0);
    checkOutput("rst_d_resp_valid", {31'b0, d_resp_valid}, 32'd0);
    checkOutput("rst_f_resp_data", f_resp_data, 32'd0);
    checkOutput("rst_d_resp_data", d_resp_data, 32'd0);
    checkOutput("rst_f_resp_err", {31'b0, f_resp_err}, 32'd0);
    checkOutput("rst_d_resp_err", {31'b0, d_resp_err}, 32'd0);
    checkOutput("rst_mem_a", mem_a, 32'd0);
    fQ.delete();
    dQ.delete();
    mFFull = 1'b0; mDFull = 1'b0; mStarve = 0; mMemA = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    doReset();

    // Single aligned fetch, held one cycle, then popped.
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Misaligned and out-of-range fetches.
    applyStimulus(1'b1, 32'h6,   1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Backpressure, then pop plus new request in the same cycle.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h18, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Flush a held fetch while debug is still served.
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0);
    applyStimulus(1'b1, 32'h24, 1'b0, 1'b1, 1'b1, 32'h30, 1'b0);
    applyStimulus(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b1);

    // Continuous contention: D must win exactly every fifth cycle.
    obsDGrants = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 32'h40 + 32'(4 * i), 1'b1, 1'b0, 1'b1, 32'h80 + 32'(4 * i), 1'b1);
    end
    checkOutput("d_grant_share", 32'(obsDGrants), 32'd3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset with both slots full.
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    doReset();

    // Reset with a partly advanced starvation count, then normal service resumes.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h50 + 32'(4 * i), 1'b1, 1'b0, 1'b1, 32'h90, 1'b1);
    end
    doReset();
    obsDGrants = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h8 + 32'(4 * i), 1'b1, 1'b0, 1'b1, 32'hFC, 1'b1);
    end
    checkOutput("post_reset_d_grants", 32'(obsDGrants), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single combinational read port of the instruction ROM between two requesters: the IF stage (port F) and the debug/program-inspection port (port D).
- Sits between the fetch unit / debug controller and the instruction memory.
- Provides valid/ready request handshakes, one registered response slot per port, a 1-cycle response latency, misaligned/out-of-range error flagging, and starvation-bounded fixed priority.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 64, ROM depth in words; word indices >= DEPTH are out of range.
- STARVE_LIMIT, 4, consecutive denied cycles after which port D wins over port F.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- f_req_valid  in  1  fetch request valid.
- f_req_ready  out  1  fetch request accepted this cycle when high with f_req_valid.
- f_req_addr  in  XLEN  fetch byte address.
- f_resp_valid  out  1  fetch response held.
- f_resp_ready  in  1  fetch consumer pops response.
- f_resp_data  out  XLEN  instruction word.
- f_resp_err  out  1  misaligned or out-of-range fetch.
- f_flush  in  1  branch redirect: discard fetch response.
- d_req_valid / d_req_ready / d_req_addr / d_resp_valid / d_resp_ready / d_resp_data / d_resp_err  same as F-port equivalents, for port D.
- mem_a  out  XLEN  address to ROM (byte address; ROM indexes a[31:2]).
- mem_rd  in  XLEN  ROM read data, combinational from mem_a.

Behaviour:
- Reset: all resp_valid=0, resp_data=0, resp_err=0, starvation counter=0, mem_a=0. No pending state survives reset. Reset asserted mid-transaction drops that transaction silently.
- Slot state per port: EMPTY/FULL. A port is eligible when req_valid and (slot EMPTY, or slot FULL and resp_ready this cycle). Port F is additionally ineligible while f_flush=1.
- Grant, evaluated combinationally each cycle, at most one port:
  - D if D eligible and (F not eligible, or starve_cnt == STARVE_LIMIT).
  - Otherwise F if F eligible.
- req_ready is high only for the granted port.
- mem_a = granted address. With no grant, mem_a holds its previous value; there is no toggling when idle.
- Acceptance at cycle N:
  - At the N+1 edge the slot becomes FULL, resp_data = mem_rd sampled at N, and resp_err = (addr[1:0] != 0) or (addr[31:2] >= DEPTH).
  - On error, resp_data = 0.
  - Latency: exactly 1 cycle request-to-response.
- A FULL slot holds data/err stable until resp_ready. Pop and new acceptance in the same cycle leaves the slot FULL with new data; there are no bubbles.
- f_flush=1: the F slot goes EMPTY at the next edge regardless of f_resp_ready. F is not granted that cycle. D is unaffected.
- Starvation counter (width $clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, when D is eligible but not granted.
  - Clears on a D grant.
  - Holds otherwise.
- Port F can never be starved longer than 1 cycle per STARVE_LIMIT+1 cycles under continuous D load.

Optional Feature:
- Macro IMEM_ARB_STATS_EN.
- When defined: adds outputs f_grant_cnt, d_grant_cnt, err_cnt (32 bit each).
  - The grant counters increment on each acceptance for their port.
  - err_cnt increments when an erroring response is loaded into a slot.
  - All counters wrap at 2^32 and reset to 0.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package imem_pkg: XLEN, DEPTH default, port index enum (PORT_F, PORT_D), addr_check function (alignment and range).
- One sub-module, imem_resp_slot: the registered EMPTY/FULL response holder with load/pop/flush, instantiated twice.

Test Plan:
- Single fetch to 0x0000_0008 with ROM[2]=0x00500093 -> f_resp_valid next cycle, data 0x00500093, err=0.
- F and D both valid continuously with STARVE_LIMIT=4 -> D granted exactly every 5th cycle; F gets the other 4 of every 5 grants.
- Fetch to 0x0000_0006 (misaligned) and to 0x0000_0100 (index 64) -> both return err=1, data=0.
- F slot FULL, f_resp_ready=0, new f_req_valid -> f_req_ready=0 until pop. Pop plus request in the same cycle -> back-to-back responses with no gap.
- F response held and f_flush=1 with f_req_valid=1 -> slot EMPTY next cycle, no F grant that cycle, D request in the same cycle still served.
- rst_n asserted mid-stream with both slots FULL -> all resp_valid=0 immediately (asynchronously), starve_cnt=0; first request after release is served normally.
